// File: rtl/cpu_commit_pkg.sv
// cpu_commit_pkg: shared CPU commit-stage types and constants.
package cpu_commit_pkg;
   typedef enum logic [0:0] {IDLE, MEM_WAIT} commit_state_t;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/cpu_commit_if.sv
// cpu_commit_if: execute, data-memory and writeback signals of the commit stage.
interface cpu_commit_if #(parameter int DATA_WIDTH = 32, parameter int REG_ADDR_WIDTH = 5);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     alu_result;
   logic [DATA_WIDTH-1:0]     rb_data;
   logic [REG_ADDR_WIDTH-1:0] reg_dest;
   logic                      writeback;
   logic                      mem_read;
   logic                      mem_write;
   logic                      mem_byte;
   logic                      dmem_req;
   logic                      dmem_we;
   logic [DATA_WIDTH-1:0]     dmem_addr;
   logic [DATA_WIDTH-1:0]     dmem_wdata;
   logic                      dmem_byte;
   logic                      dmem_ack;
   logic [DATA_WIDTH-1:0]     dmem_rdata;
   logic                      wb_valid;
   logic [DATA_WIDTH-1:0]     wb_data;
   logic [REG_ADDR_WIDTH-1:0] wb_reg_dest;
   logic                      wb_writeback;
   logic                      misalign;
   modport slave (
      input  in_valid, alu_result, rb_data, reg_dest, writeback, mem_read, mem_write, mem_byte,
             dmem_ack, dmem_rdata,
      output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte,
             wb_valid, wb_data, wb_reg_dest, wb_writeback, misalign
   );
   modport master (
      output in_valid, alu_result, rb_data, reg_dest, writeback, mem_read, mem_write, mem_byte,
             dmem_ack, dmem_rdata,
      input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte,
             wb_valid, wb_data, wb_reg_dest, wb_writeback, misalign
   );
endinterface

// File: rtl/cpu_load_align.sv
// cpu_load_align: returns the full read word or its zero-extended low byte.
module cpu_load_align #(parameter int DATA_WIDTH = 32) (
   input  logic                  byte_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic [DATA_WIDTH-1:0] data_o
);
   assign data_o = byte_i ? {{(DATA_WIDTH-8){1'b0}}, rdata_i[7:0]} : rdata_i;
endmodule

// File: rtl/cpu_commit.sv
// cpu_commit: memory-access stage; registers ALU results, runs loads/stores over a
// req/ack port, traps misaligned word accesses and hands results to writeback.
module cpu_commit
   import cpu_commit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input logic          clock,
   input logic          reset,
   cpu_commit_if.slave  bus
);
   commit_state_t             state_q, state_d;
   logic                      req_q, req_d, we_q, we_d, byte_q, byte_d;
   logic [DATA_WIDTH-1:0]     addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
   logic                      wb_valid_q, wb_valid_d, wb_wb_q, wb_wb_d, mis_q, mis_d;
   logic                      pend_wb_q, pend_wb_d;
   logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
   logic [DATA_WIDTH-1:0]     load_data;
   logic                      is_mem, is_misaligned;
   cpu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .byte_i  (byte_q),
      .rdata_i (bus.dmem_rdata),
      .data_o  (load_data)
   );
   assign is_mem        = bus.mem_read | bus.mem_write;
   assign is_misaligned = !bus.mem_byte && ((bus.alu_result[1:0] & ALIGN_MASK) != 2'b00);
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      byte_d     = byte_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_data_d  = wb_data_q;
      wb_dest_d  = wb_dest_q;
      wb_wb_d    = wb_wb_q;
      pend_wb_d  = pend_wb_q;
      wb_valid_d = 1'b0;
      mis_d      = 1'b0;
      if (state_q == IDLE) begin
         if (bus.in_valid) begin
            wb_dest_d = bus.reg_dest;
            if (!is_mem || is_misaligned) begin
               wb_valid_d = 1'b1;
               mis_d      = is_mem;
               wb_data_d  = bus.alu_result;
               wb_wb_d    = is_mem ? 1'b0 : bus.writeback;
            end else begin
               req_d     = 1'b1;
               we_d      = bus.mem_write;
               addr_d    = bus.alu_result;
               wdata_d   = bus.rb_data;
               byte_d    = bus.mem_byte;
               pend_wb_d = bus.writeback & bus.mem_read;
               state_d   = MEM_WAIT;
            end
         end
      end else if (bus.dmem_ack) begin
         req_d      = 1'b0;
         state_d    = IDLE;
         wb_valid_d = 1'b1;
         wb_data_d  = load_data;
         wb_wb_d    = pend_wb_q;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         byte_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_data_q  <= '0;
         wb_dest_q  <= '0;
         wb_wb_q    <= 1'b0;
         pend_wb_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         byte_q     <= byte_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_data_q  <= wb_data_d;
         wb_dest_q  <= wb_dest_d;
         wb_wb_q    <= wb_wb_d;
         pend_wb_q  <= pend_wb_d;
         wb_valid_q <= wb_valid_d;
         mis_q      <= mis_d;
      end
   end
   assign bus.in_ready     = (state_q == IDLE);
   assign bus.dmem_req     = req_q;
   assign bus.dmem_we      = we_q;
   assign bus.dmem_addr    = addr_q;
   assign bus.dmem_wdata   = wdata_q;
   assign bus.dmem_byte    = byte_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.wb_reg_dest  = wb_dest_q;
   assign bus.wb_writeback = wb_wb_q;
   assign bus.misalign     = mis_q;
endmodule

// File: tb/tb_cpu_commit.sv
// tb_cpu_commit: directed checks of the commit stage against hand-computed values.
module tb_cpu_commit;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   cpu_commit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
   cpu_commit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic idle_inputs();
      bus.in_valid = 0; bus.alu_result = 0; bus.rb_data = 0; bus.reg_dest = 0;
      bus.writeback = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_byte = 0;
      bus.dmem_ack = 0; bus.dmem_rdata = 0;
   endtask
   initial begin
      idle_inputs();
      #3;
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_req", 32'(bus.dmem_req), 0);
      chk("rst_wb_valid", 32'(bus.wb_valid), 0);
      chk("rst_misalign", 32'(bus.misalign), 0);
      chk("rst_wb_data", bus.wb_data, 0);
      chk("rst_addr", bus.dmem_addr, 0);
      @(negedge clock);
      reset = 1;
      tick();
      // ALU pass-through
      bus.in_valid = 1; bus.alu_result = 32'h12345678; bus.reg_dest = 3; bus.writeback = 1;
      tick();
      idle_inputs();
      chk("alu_wb_valid", 32'(bus.wb_valid), 1);
      chk("alu_wb_data", bus.wb_data, 32'h12345678);
      chk("alu_wb_dest", 32'(bus.wb_reg_dest), 3);
      chk("alu_wb_we", 32'(bus.wb_writeback), 1);
      chk("alu_in_ready", 32'(bus.in_ready), 1);
      chk("alu_no_req", 32'(bus.dmem_req), 0);
      tick();
      chk("alu_pulse_end", 32'(bus.wb_valid), 0);
      // Word load, ack in third request cycle
      bus.in_valid = 1; bus.alu_result = 32'h100; bus.reg_dest = 5; bus.writeback = 1; bus.mem_read = 1;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         chk("ld_req", 32'(bus.dmem_req), 1);
         chk("ld_addr", bus.dmem_addr, 32'h100);
         chk("ld_we", 32'(bus.dmem_we), 0);
         chk("ld_in_ready", 32'(bus.in_ready), 0);
         chk("ld_wb_idle", 32'(bus.wb_valid), 0);
         if (i == 2) begin
            bus.dmem_ack = 1; bus.dmem_rdata = 32'hDEADBEEF;
         end
         tick();
      end
      idle_inputs();
      chk("ld_req_drop", 32'(bus.dmem_req), 0);
      chk("ld_wb_valid", 32'(bus.wb_valid), 1);
      chk("ld_wb_data", bus.wb_data, 32'hDEADBEEF);
      chk("ld_wb_dest", 32'(bus.wb_reg_dest), 5);
      chk("ld_wb_we", 32'(bus.wb_writeback), 1);
      chk("ld_in_ready_back", 32'(bus.in_ready), 1);
      tick();
      // Byte load, odd address
      bus.in_valid = 1; bus.alu_result = 32'h101; bus.reg_dest = 6; bus.writeback = 1;
      bus.mem_read = 1; bus.mem_byte = 1;
      tick();
      idle_inputs();
      chk("lb_req", 32'(bus.dmem_req), 1);
      chk("lb_byte", 32'(bus.dmem_byte), 1);
      chk("lb_addr", bus.dmem_addr, 32'h101);
      chk("lb_no_mis", 32'(bus.misalign), 0);
      bus.dmem_ack = 1; bus.dmem_rdata = 32'hAABBCCDD;
      tick();
      idle_inputs();
      chk("lb_wb_valid", 32'(bus.wb_valid), 1);
      chk("lb_wb_data", bus.wb_data, 32'h000000DD);
      chk("lb_no_mis2", 32'(bus.misalign), 0);
      tick();
      // Misaligned word store
      bus.in_valid = 1; bus.alu_result = 32'h202; bus.rb_data = 32'h11112222; bus.mem_write = 1;
      tick();
      idle_inputs();
      chk("mis_no_req", 32'(bus.dmem_req), 0);
      chk("mis_pulse", 32'(bus.misalign), 1);
      chk("mis_wb_valid", 32'(bus.wb_valid), 1);
      chk("mis_wb_we", 32'(bus.wb_writeback), 0);
      chk("mis_in_ready", 32'(bus.in_ready), 1);
      tick();
      chk("mis_pulse_end", 32'(bus.misalign), 0);
      chk("mis_still_no_req", 32'(bus.dmem_req), 0);
      // Store with immediate ack, then ALU op back-to-back
      bus.in_valid = 1; bus.alu_result = 32'h204; bus.rb_data = 32'hCAFEF00D; bus.mem_write = 1;
      tick();
      idle_inputs();
      chk("st_req", 32'(bus.dmem_req), 1);
      chk("st_we", 32'(bus.dmem_we), 1);
      chk("st_wdata", bus.dmem_wdata, 32'hCAFEF00D);
      chk("st_addr", bus.dmem_addr, 32'h204);
      bus.dmem_ack = 1;
      tick();
      idle_inputs();
      chk("st_wb_valid", 32'(bus.wb_valid), 1);
      chk("st_wb_we", 32'(bus.wb_writeback), 0);
      chk("st_req_drop", 32'(bus.dmem_req), 0);
      chk("st_in_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1; bus.alu_result = 32'h55; bus.reg_dest = 7; bus.writeback = 1;
      tick();
      idle_inputs();
      chk("b2b_wb_valid", 32'(bus.wb_valid), 1);
      chk("b2b_wb_data", bus.wb_data, 32'h55);
      chk("b2b_wb_dest", 32'(bus.wb_reg_dest), 7);
      tick();
      // Reset during MEM_WAIT aborts the access
      bus.in_valid = 1; bus.alu_result = 32'h300; bus.reg_dest = 9; bus.writeback = 1; bus.mem_read = 1;
      tick();
      idle_inputs();
      chk("rstw_req", 32'(bus.dmem_req), 1);
      #2;
      reset = 0;
      #1;
      chk("rstw_req_async", 32'(bus.dmem_req), 0);
      chk("rstw_in_ready", 32'(bus.in_ready), 1);
      @(negedge clock);
      reset = 1;
      bus.dmem_ack = 1; bus.dmem_rdata = 32'h77777777;
      tick();
      chk("rstw_no_wb", 32'(bus.wb_valid), 0);
      chk("rstw_idle_ack_req", 32'(bus.dmem_req), 0);
      chk("rstw_in_ready2", 32'(bus.in_ready), 1);
      idle_inputs();
      tick();
      chk("rstw_no_wb2", 32'(bus.wb_valid), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_commit.md
# cpu_commit

Commit (memory-access) stage of the CPU pipeline, directly downstream of the execute stage. It registers the ALU result and store data, performs loads and stores over a request/acknowledge data-memory port, and then hands the result to writeback. While a memory access is in flight it back-pressures execute through `in_ready`. Misaligned word accesses are trapped without touching memory.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: datapath width; must be a multiple of 8.
- `REG_ADDR_WIDTH`, default 5: register-index width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  execute presents an instruction.
- `in_ready`  out  1  stage accepts this cycle; transfer when `in_valid && in_ready`.
- `alu_result`  in  DATA_WIDTH  ALU result; also the memory address.
- `rb_data`  in  DATA_WIDTH  store data.
- `reg_dest`  in  REG_ADDR_WIDTH  destination register.
- `writeback`  in  1  instruction writes the register file.
- `mem_read`  in  1  load.
- `mem_write`  in  1  store; asserting both `mem_read` and `mem_write` is illegal.
- `mem_byte`  in  1  byte access; 0 selects a full-word access.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  DATA_WIDTH  byte address.
- `dmem_wdata`  out  DATA_WIDTH  write data.
- `dmem_byte`  out  1  byte-size access.
- `dmem_ack`  in  1  memory completion.
- `dmem_rdata`  in  DATA_WIDTH  read data; valid when `dmem_ack` is high.
- `wb_valid`  out  1  one-cycle pulse: result available to writeback.
- `wb_data`  out  DATA_WIDTH  result.
- `wb_reg_dest`  out  REG_ADDR_WIDTH  destination register.
- `wb_writeback`  out  1  register-file write enable.
- `misalign`  out  1  one-cycle pulse: a word access had `alu_result[1:0] != 0`.

## Operation
- FSM states: IDLE, MEM_WAIT.
- `in_ready = (state == IDLE)`.
- IDLE, accepted non-memory instruction:
  - Next cycle: `wb_valid=1`, `wb_data=alu_result`, with `reg_dest` and `writeback` passed through.
  - State stays IDLE.
- IDLE, accepted memory instruction, aligned (byte access, or word access with `addr[1:0]==0`):
  - Register `dmem_req=1`, `dmem_we=mem_write`, `dmem_addr`, `dmem_wdata=rb_data`, `dmem_byte`.
  - Go to MEM_WAIT.
- IDLE, accepted word access with `addr[1:0]!=0`:
  - No request is issued.
  - Next cycle: `misalign=1`, `wb_valid=1`, `wb_writeback=0`.
  - State stays IDLE.
- MEM_WAIT:
  - All `dmem_*` outputs are held stable until `dmem_ack`.
  - On the ack edge: `dmem_req` drops and the FSM returns to IDLE.
  - Same edge, load: `wb_valid=1`; `wb_data=dmem_rdata`, or for a byte access `{zeros, dmem_rdata[7:0]}` (zero-extended).
  - Same edge, store: `wb_valid=1`, `wb_writeback=0`.
- `dmem_ack` is ignored while `dmem_req` is low.
- Reset values:
  - State IDLE; `dmem_req`, `dmem_we`, `dmem_byte`, `wb_valid`, `wb_writeback`, `misalign` = 0.
  - `dmem_addr`, `dmem_wdata`, `wb_data`, `wb_reg_dest` = 0.
- Reset asserted mid-access aborts it: `dmem_req` drops asynchronously and no `wb_valid` is produced.

## Timing
- Non-memory instruction: `wb_valid` one cycle after acceptance; throughput one per cycle.
- Memory instruction:
  - `dmem_req` rises one cycle after acceptance.
  - The earliest ack is in the first cycle `dmem_req` is high; `wb_valid` follows at the next edge.
  - Minimum occupancy is 2 cycles. `in_ready` is low for every MEM_WAIT cycle and rises in the cycle after the ack edge.
- A new instruction is accepted in the same cycle `wb_valid` is high for the previous one; there is no bubble.
- All outputs are registered; no combinational path from `dmem_ack` to `in_ready`.

## Structure
- The shared CPU package holds the FSM state enum `commit_state_t` and the constant `ALIGN_MASK = 2'b11`.
- One sub-module: `cpu_load_align`, combinational. It selects `dmem_rdata` or the zero-extended byte based on `dmem_byte`.

## Test plan
- ALU pass-through: `alu_result=0x12345678`, `reg_dest=3`, `writeback=1`, no memory op -> next cycle `wb_valid=1`, `wb_data=0x12345678`, `wb_reg_dest=3`; `in_ready` stays 1.
- Word load with 3-cycle ack delay: `addr=0x100`, `dmem_rdata=0xDEADBEEF` -> `dmem_req` high 3 cycles with the address stable; `in_ready` low throughout; `wb_data=0xDEADBEEF`.
- Byte load: `addr=0x101`, `dmem_rdata=0xAABBCCDD` -> `wb_data=0x000000DD`; no misalign.
- Word store: `addr=0x202` -> no `dmem_req`; `misalign` pulse; `wb_writeback=0`.
- Back-to-back: store (ack immediate), then ALU op -> the ALU op is accepted the cycle after the ack edge, and its `wb_valid` follows the store's `wb_valid` by exactly one cycle.
- Reset low during MEM_WAIT -> `dmem_req` drops immediately; after release, state IDLE, `in_ready=1`, no spurious `wb_valid`.
